// File: rtl/rca_cfg_loader_if.sv
// Bus bundle for rca_cfg_loader: issue-side switch handshake, config ROM read port,
// grid config write port and load status.
interface rca_cfg_loader_if #(
    parameter int NUM_RCAS   = 4,
    parameter int CFG_WORDS  = 16,
    parameter int CFG_DATA_W = 32
);
    localparam int STRIDE = CFG_WORDS + 1;
    localparam int ROM_AW = $clog2(NUM_RCAS * STRIDE);
    localparam int SEL_W  = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
    localparam int WA_W   = $clog2(CFG_WORDS);

    logic                  switch_req;
    logic [SEL_W-1:0]      switch_rca_sel;
    logic                  switch_ready;
    logic                  grid_idle;
    logic                  cfg_rom_rd;
    logic [ROM_AW-1:0]     cfg_rom_addr;
    logic [CFG_DATA_W-1:0] cfg_rom_data;
    logic                  cfg_wr_en;
    logic [WA_W-1:0]       cfg_wr_addr;
    logic [CFG_DATA_W-1:0] cfg_wr_data;
    logic                  cfg_done;
    logic                  loaded_valid;
    logic [SEL_W-1:0]      loaded_rca;
    logic                  busy;
    logic                  cfg_error;

    modport slave (
        input  switch_req, switch_rca_sel, grid_idle, cfg_rom_data,
        output switch_ready, cfg_rom_rd, cfg_rom_addr, cfg_wr_en, cfg_wr_addr,
               cfg_wr_data, cfg_done, loaded_valid, loaded_rca, busy, cfg_error
    );

    modport master (
        output switch_req, switch_rca_sel, grid_idle, cfg_rom_data,
        input  switch_ready, cfg_rom_rd, cfg_rom_addr, cfg_wr_en, cfg_wr_addr,
               cfg_wr_data, cfg_done, loaded_valid, loaded_rca, busy, cfg_error
    );
endinterface

// File: rtl/rca_cfg_loader.sv
// Reconfiguration sequencer: waits for the RCA grid to drain, then streams one RCA image
// from the config ROM into the grid. Define RCA_CFG_CHECKSUM_EN to verify each image's XOR checksum.
module rca_cfg_loader #(
    parameter int NUM_RCAS   = 4,
    parameter int CFG_WORDS  = 16,
    parameter int CFG_DATA_W = 32
) (
    input logic           clk,
    input logic           rst,
    rca_cfg_loader_if.slave bus
);
    localparam int STRIDE = CFG_WORDS + 1;
    localparam int ROM_AW = $clog2(NUM_RCAS * STRIDE);
    localparam int SEL_W  = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
    localparam int WA_W   = $clog2(CFG_WORDS);
    localparam int IDX_W  = $clog2(CFG_WORDS + 1);

`ifdef RCA_CFG_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CFG_WORDS);
`else
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CFG_WORDS - 1);
`endif

    typedef enum logic [2:0] {IDLE, WAIT_IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state;
    logic [SEL_W-1:0]  target;
    logic [SEL_W-1:0]  loaded_rca;
    logic [SEL_W-1:0]  load_sel;
    logic              loaded_valid;
    logic              hit_r;
    logic              cfg_done;
    logic              rom_rd;
    logic              rd_r;
    logic              sum_bad;
    logic              cfg_error;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_r;
    logic [ROM_AW-1:0] rom_addr;
    logic              hit;
    logic              start_load;
    logic              wr_en;

    function automatic logic [ROM_AW-1:0] rca_base(input logic [SEL_W-1:0] sel);
        return ROM_AW'(sel) * ROM_AW'(STRIDE);
    endfunction

    assign hit = loaded_valid && (loaded_rca == bus.switch_rca_sel);

    // Load start is shared by the direct IDLE path and the WAIT_IDLE path.
    always_comb begin
        start_load = 1'b0;
        load_sel   = target;
        case (state)
            IDLE: begin
                start_load = bus.switch_req && !hit && bus.grid_idle;
                load_sel   = bus.switch_rca_sel;
            end
            WAIT_IDLE: start_load = bus.grid_idle;
            default: ;
        endcase
    end

    // ROM data lags the read strobe by one cycle; the checksum slot is read but never written.
    assign wr_en = rd_r && (idx_r < IDX_W'(CFG_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target       <= '0;
            hit_r        <= 1'b0;
            loaded_valid <= 1'b0;
            loaded_rca   <= '0;
            cfg_done     <= 1'b0;
            rom_rd       <= 1'b0;
            rom_addr     <= '0;
            idx          <= '0;
            idx_r        <= '0;
            rd_r         <= 1'b0;
        end else begin
            rd_r     <= rom_rd;
            idx_r    <= idx;
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.switch_req) begin
                        target <= bus.switch_rca_sel;
                        hit_r  <= hit;
                        if (hit) begin
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end else if (!bus.grid_idle) begin
                            state <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: ;
                LOAD: begin
                    if (idx == LAST) begin
                        rom_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        idx      <= idx + 1'b1;
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    cfg_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    if (!hit_r && !sum_bad) begin
                        loaded_valid <= 1'b1;
                        loaded_rca   <= target;
                    end
                end
                default: state <= IDLE;
            endcase
            if (start_load) begin
                state        <= LOAD;
                rom_rd       <= 1'b1;
                idx          <= '0;
                rom_addr     <= rca_base(load_sel);
                loaded_valid <= 1'b0;
            end
        end
    end

`ifdef RCA_CFG_CHECKSUM_EN
    logic [CFG_DATA_W-1:0] acc;

    // In DRAIN the ROM output is the checksum slot; acc already holds every written word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            sum_bad   <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            if (wr_en)
                acc <= acc ^ bus.cfg_rom_data;
            if (start_load) begin
                acc     <= '0;
                sum_bad <= 1'b0;
            end
            if (state == DRAIN && acc != bus.cfg_rom_data) begin
                sum_bad   <= 1'b1;
                cfg_error <= 1'b1;
            end
        end
    end
`else
    assign sum_bad   = 1'b0;
    assign cfg_error = 1'b0;
`endif

    assign bus.switch_ready = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.cfg_rom_rd   = rom_rd;
    assign bus.cfg_rom_addr = rom_addr;
    assign bus.cfg_wr_en    = wr_en;
    assign bus.cfg_wr_addr  = idx_r[WA_W-1:0];
    assign bus.cfg_wr_data  = bus.cfg_rom_data;
    assign bus.cfg_done     = cfg_done;
    assign bus.loaded_valid = loaded_valid;
    assign bus.loaded_rca   = loaded_rca;
    assign bus.cfg_error    = cfg_error;
endmodule

// File: tb/tb_rca_cfg_loader.sv
// Self-checking bench for rca_cfg_loader: randomized ROM images and requests checked
// against a cycle-schedule reference model of the loader.
module tb_rca_cfg_loader;
    localparam int NR     = 4;
    localparam int NW     = 16;
    localparam int DW     = 32;
    localparam int STRIDE = NW + 1;
`ifdef RCA_CFG_CHECKSUM_EN
    localparam int NRD = NW + 1;
`else
    localparam int NRD = NW;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rca_cfg_loader_if #(.NUM_RCAS(NR), .CFG_WORDS(NW), .CFG_DATA_W(DW)) bus();

    rca_cfg_loader #(.NUM_RCAS(NR), .CFG_WORDS(NW), .CFG_DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 = ROM read, 1 = grid write, 2 = done pulse
        logic [31:0] cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t         obs[$];
    ev_t         exp_q[$];
    bit          lv_hist  [8192];
    bit          rdy_hist [8192];
    logic [DW-1:0] rom [0:127];
    int          cyc = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          fails = 0;
    bit          m_valid = 1'b0;
    int          m_rca = 0;
    bit          m_err = 1'b0;

    function automatic ev_t mk(input int k, input int c, input int a, input logic [31:0] d);
        ev_t e;
        e.kind = k[1:0];
        e.cyc  = c;
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.cfg_rom_rd) bus.cfg_rom_data <= rom[bus.cfg_rom_addr];

    always @(negedge clk) begin
        if (cyc < 8192) begin
            lv_hist[cyc]  <= bus.loaded_valid;
            rdy_hist[cyc] <= bus.switch_ready;
        end
        if (bus.cfg_rom_rd) obs.push_back(mk(0, cyc, int'(bus.cfg_rom_addr), '0));
        if (bus.cfg_wr_en)  obs.push_back(mk(1, cyc, int'(bus.cfg_wr_addr), bus.cfg_wr_data));
        if (bus.cfg_done) begin
            obs.push_back(mk(2, cyc, 0, '0));
            done_cnt <= done_cnt + 1;
        end
    end

    // Reference: a miss reads the image one word per cycle, each word is written one
    // cycle after its read, and done follows the drain cycle; a hit is just a done pulse.
    task automatic model_txn(input int sel, input int a_cyc, input int g);
        int r0, dn;
        logic [DW-1:0] x;
        if (m_valid && m_rca == sel) begin
            exp_q.push_back(mk(2, a_cyc + 1, 0, '0));
        end else begin
            r0 = a_cyc + 1 + g;
            dn = r0 + NRD + 1;
            for (int c = r0; c <= dn; c++) begin
                if (c < r0 + NRD) exp_q.push_back(mk(0, c, sel * STRIDE + (c - r0), '0));
                if (c > r0 && c <= r0 + NW)
                    exp_q.push_back(mk(1, c, c - r0 - 1, rom[sel * STRIDE + c - r0 - 1]));
                if (c == dn) exp_q.push_back(mk(2, c, 0, '0));
            end
            m_valid = 1'b1;
            m_rca   = sel;
            x = '0;
            for (int i = 0; i < NW; i++) x = x ^ rom[sel * STRIDE + i];
`ifdef RCA_CFG_CHECKSUM_EN
            if (x != rom[sel * STRIDE + NW]) begin
                m_valid = 1'b0;
                m_err   = 1'b1;
            end
`endif
        end
    endtask

    task automatic clear_logs();
        obs.delete();
        exp_q.delete();
    endtask

    // Holds switch_req until accepted; grid_idle is held low for g cycles from the accept cycle.
    task automatic issue(input int sel, input int g, output int a_cyc);
        int n = 0;
        @(negedge clk);
        bus.switch_req     = 1'b1;
        bus.switch_rca_sel = sel[1:0];
        if (g > 0) bus.grid_idle = 1'b0;
        while (!bus.switch_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.switch_ready) begin
            fails++;
            $display("FAIL accept_timeout: switch_ready=%0b after %0d cycles, want 1", bus.switch_ready, n);
        end
        a_cyc = cyc;
        @(negedge clk);
        bus.switch_req = 1'b0;
        if (g > 0) begin
            repeat (g - 1) @(negedge clk);
            bus.grid_idle = 1'b1;
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            fails++;
            $display("FAIL done_timeout: done count %0d, want %0d", done_cnt, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.switch_req     = 1'b0;
        bus.switch_rca_sel = '0;
        bus.grid_idle      = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.switch_ready, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_ready: ready/busy=%b want 10", {bus.switch_ready, bus.busy});
        end
        checks++;
        if ({bus.loaded_valid, bus.loaded_rca, bus.cfg_error} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_loaded: valid/rca/err=%b want 0000", {bus.loaded_valid, bus.loaded_rca, bus.cfg_error});
        end
        checks++;
        if ({bus.cfg_done, bus.cfg_wr_en, bus.cfg_rom_rd, bus.cfg_rom_addr} !== 10'd0) begin
            fails++;
            $display("FAIL reset_strobes: done/wr/rd/addr=%b want 0", {bus.cfg_done, bus.cfg_wr_en, bus.cfg_rom_rd, bus.cfg_rom_addr});
        end
        rst = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic test_miss_idle();
        int a0, base;
        clear_logs();
        base = done_cnt;
        issue(2, 0, a0);
        model_txn(2, a0, 0);
        wait_done(base + 1);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL miss_idle_count: got %0d events, want %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL miss_idle_ev[%0d]: got k%0d c%0d a%0d d%h, want k%0d c%0d a%0d d%h", i,
                         obs[i].kind, obs[i].cyc, obs[i].a, obs[i].d, exp_q[i].kind, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++;
        if (lv_hist[a0 + NRD + 2] !== 1'b0 || lv_hist[a0 + NRD + 3] !== m_valid) begin
            fails++;
            $display("FAIL miss_idle_valid: at done %0b after %0b, want 0 then %0b",
                     lv_hist[a0 + NRD + 2], lv_hist[a0 + NRD + 3], m_valid);
        end
        checks++;
        if (bus.loaded_rca !== 2'd2) begin
            fails++;
            $display("FAIL miss_idle_rca: got %0d want 2", bus.loaded_rca);
        end
    endtask

    task automatic test_hit();
        int a0, base;
        clear_logs();
        base = done_cnt;
        issue(2, 0, a0);
        model_txn(2, a0, 0);
        wait_done(base + 1);
        checks++;
        if (obs.size() != 1 || obs[0] !== mk(2, a0 + 1, 0, '0)) begin
            fails++;
            $display("FAIL hit_events: got %0d events (first cyc %0d), want only done at %0d",
                     obs.size(), (obs.size() > 0) ? int'(obs[0].cyc) : -1, a0 + 1);
        end
        checks++;
        if (rdy_hist[a0 + 1] !== 1'b0 || rdy_hist[a0 + 2] !== 1'b1) begin
            fails++;
            $display("FAIL hit_ready: ready at A+1=%0b A+2=%0b, want 0 1", rdy_hist[a0 + 1], rdy_hist[a0 + 2]);
        end
        checks++;
        if ({bus.loaded_valid, bus.loaded_rca} !== {m_valid, m_rca[1:0]}) begin
            fails++;
            $display("FAIL hit_loaded: got %b want %b", {bus.loaded_valid, bus.loaded_rca}, {m_valid, m_rca[1:0]});
        end
    endtask

    task automatic test_wait_idle();
        int a0, base, ones;
        bit prev_valid;
        clear_logs();
        base = done_cnt;
        prev_valid = m_valid;
        issue(1, 5, a0);
        model_txn(1, a0, 5);
        wait_done(base + 1);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL wait_idle_count: got %0d events, want %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL wait_idle_ev[%0d]: got k%0d c%0d a%0d d%h, want k%0d c%0d a%0d d%h", i,
                         obs[i].kind, obs[i].cyc, obs[i].a, obs[i].d, exp_q[i].kind, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++;
        if (lv_hist[a0 + 5] !== prev_valid) begin
            fails++;
            $display("FAIL wait_idle_keep: loaded_valid while waiting %0b, want %0b", lv_hist[a0 + 5], prev_valid);
        end
        ones = 0;
        for (int c = a0 + 6; c <= a0 + 5 + NRD + 2; c++) ones += int'(lv_hist[c]);
        checks++;
        if (ones != 0) begin
            fails++;
            $display("FAIL wait_idle_clear: loaded_valid high %0d cycles during load, want 0", ones);
        end
        checks++;
        if ({bus.loaded_valid, bus.loaded_rca} !== {m_valid, m_rca[1:0]}) begin
            fails++;
            $display("FAIL wait_idle_loaded: got %b want %b", {bus.loaded_valid, bus.loaded_rca}, {m_valid, m_rca[1:0]});
        end
    endtask

    task automatic test_reset_mid();
        int a0, n, rc, late;
        clear_logs();
        issue(3, 0, a0);
        n = 0;
        while (!(bus.cfg_wr_en && bus.cfg_wr_addr == 4'd7) && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        rc  = cyc;
        @(negedge clk);
        checks++;
        if ({bus.switch_ready, bus.loaded_valid, bus.cfg_wr_en, bus.cfg_rom_rd} !== 4'b1000) begin
            fail_reset_mid(rc, {bus.switch_ready, bus.loaded_valid, bus.cfg_wr_en, bus.cfg_rom_rd});
        end
        rst = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        repeat (6) @(negedge clk);
        late = 0;
        foreach (obs[i]) if (obs[i].kind == 2'd1 && int'(obs[i].cyc) > rc) late++;
        checks++;
        if (late != 0 || bus.loaded_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_after: %0d writes after reset, loaded_valid=%0b, want 0 and 0", late, bus.loaded_valid);
        end
    endtask

    task automatic fail_reset_mid(input int rc, input logic [3:0] got);
        fails++;
        $display("FAIL reset_mid_state: ready/valid/wr/rd=%b one cycle after reset at %0d, want 1000", got, rc);
    endtask

    task automatic test_held_req();
        int a1, a2, r, base;
        clear_logs();
        base = done_cnt;
        r = $urandom_range(1, 3);
        issue(r, 0, a1);
        model_txn(r, a1, 0);
        issue(0, 0, a2);
        model_txn(0, a2, 0);
        wait_done(base + 2);
        checks++;
        if (a2 != a1 + NRD + 3) begin
            fails++;
            $display("FAIL held_accept: second accept at %0d, want %0d", a2, a1 + NRD + 3);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL held_count: got %0d events, want %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL held_ev[%0d]: got k%0d c%0d a%0d d%h, want k%0d c%0d a%0d d%h", i,
                         obs[i].kind, obs[i].cyc, obs[i].a, obs[i].d, exp_q[i].kind, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_random();
        int a0, s, g, base;
        clear_logs();
        base = done_cnt;
        for (int k = 1; k <= 8; k++) begin
            s = $urandom_range(0, NR - 1);
            g = $urandom_range(0, 3);
            issue(s, g, a0);
            model_txn(s, a0, g);
            wait_done(base + k);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL random_count: got %0d events, want %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL random_ev[%0d]: got k%0d c%0d a%0d d%h, want k%0d c%0d a%0d d%h", i,
                         obs[i].kind, obs[i].cyc, obs[i].a, obs[i].d, exp_q[i].kind, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++;
        if ({bus.loaded_valid, bus.loaded_rca, bus.cfg_error} !== {m_valid, m_rca[1:0], m_err}) begin
            fails++;
            $display("FAIL random_loaded: valid/rca/err=%b want %b",
                     {bus.loaded_valid, bus.loaded_rca, bus.cfg_error}, {m_valid, m_rca[1:0], m_err});
        end
    endtask

`ifdef RCA_CFG_CHECKSUM_EN
    task automatic test_checksum();
        int a0, base;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        clear_logs();
        base = done_cnt;
        issue(1, 0, a0);
        model_txn(1, a0, 0);
        wait_done(base + 1);
        checks++;
        if ({bus.cfg_error, bus.loaded_valid} !== 2'b01) begin
            fails++;
            $display("FAIL checksum_good: err/valid=%b want 01", {bus.cfg_error, bus.loaded_valid});
        end
        issue(3, 0, a0);
        model_txn(3, a0, 0);
        wait_done(base + 2);
        rom[1 * STRIDE + 5] = rom[1 * STRIDE + 5] ^ 32'h0000_0100;
        issue(1, 0, a0);
        model_txn(1, a0, 0);
        wait_done(base + 3);
        checks++;
        if (exp_q[exp_q.size() - 1].cyc != a0 + 19 || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL checksum_sched: %0d events, want %0d with done at %0d", obs.size(), exp_q.size(), a0 + 19);
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL checksum_ev[%0d]: got k%0d c%0d a%0d d%h, want k%0d c%0d a%0d d%h", i,
                         obs[i].kind, obs[i].cyc, obs[i].a, obs[i].d, exp_q[i].kind, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
            end
        end
        checks++;
        if ({bus.cfg_error, bus.loaded_valid} !== {m_err, m_valid}) begin
            fails++;
            $display("FAIL checksum_bad: err/valid=%b want %b", {bus.cfg_error, bus.loaded_valid}, {m_err, m_valid});
        end
    endtask
`endif

    initial begin
        logic [DW-1:0] x;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        for (int r = 0; r < NR; r++) begin
            x = '0;
            for (int i = 0; i < NW; i++) x = x ^ rom[r * STRIDE + i];
            rom[r * STRIDE + NW] = x;
        end
        test_reset();
        test_miss_idle();
        test_hit();
        test_wait_idle();
        test_reset_mid();
        test_held_req();
        test_random();
`ifdef RCA_CFG_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks, %0d failures", checks, fails);
        $fatal(1);
    end
endmodule

// File: doc/rca_cfg_loader.md
Name: rca_cfg_loader

Overview:
- Reconfiguration sequencer for the RCA grid.
- On a switch request from issue-side control, it waits for the grid to drain, then streams the selected RCA's configuration words from a synchronous config ROM into the grid's configuration registers.
- It tracks which RCA is currently loaded, so a request for an already-loaded RCA completes without reloading.
- It sits between grid issue control and the grid configuration write port.

Parameters:
- NUM_RCAS, 4: number of accelerator configurations held in the ROM.
- CFG_WORDS, 16: configuration words per RCA. Must be ≥ 2.
- CFG_DATA_W, 32: configuration word width.
- Derived, not overridable:
  - STRIDE = CFG_WORDS+1. Word CFG_WORDS of each RCA region is the checksum slot.
  - ROM_AW = $clog2(NUM_RCAS*STRIDE).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- switch_req, in, 1: request to load switch_rca_sel.
- switch_rca_sel, in, $clog2(NUM_RCAS): target RCA. Sampled only when switch_req && switch_ready.
- switch_ready, out, 1: high only in IDLE.
- grid_idle, in, 1: high when no RCA instructions are in flight (ID FIFO empty).
- cfg_rom_rd, out, 1: ROM read strobe.
- cfg_rom_addr, out, ROM_AW: ROM word address.
- cfg_rom_data, in, CFG_DATA_W: ROM data, valid exactly one cycle after cfg_rom_rd.
- cfg_wr_en, out, 1: grid config register write strobe.
- cfg_wr_addr, out, $clog2(CFG_WORDS): grid config register index.
- cfg_wr_data, out, CFG_DATA_W: config word.
- cfg_done, out, 1: one-cycle pulse when a request completes (hit or load).
- loaded_valid, out, 1: grid holds a complete configuration.
- loaded_rca, out, $clog2(NUM_RCAS): RCA currently configured.
- busy, out, 1: equals ~switch_ready.
- cfg_error, out, 1: sticky checksum mismatch flag (macro only; tied 0 otherwise).

Behaviour:
- States: IDLE, WAIT_IDLE, LOAD, DRAIN, DONE.
- Reset values:
  - state = IDLE; loaded_valid = 0; loaded_rca = 0.
  - cfg_done, cfg_wr_en, cfg_rom_rd, cfg_error = 0.
  - Word index = 0; cfg_rom_addr = 0.
  - Reset mid-load abandons the load; loaded_valid stays 0.
- IDLE:
  - On accept, latch the target.
  - If hit (loaded_valid && loaded_rca == switch_rca_sel), go to DONE.
  - Else if ~grid_idle, go to WAIT_IDLE.
  - Else go to LOAD.
- WAIT_IDLE: go to LOAD in the cycle after grid_idle is sampled 1. Stay otherwise, with no timeout.
- Entering LOAD clears loaded_valid in the same edge.
- LOAD:
  - cfg_rom_rd = 1 and cfg_rom_addr = target*STRIDE + idx.
  - idx increments each cycle, from 0 to LAST.
  - LAST = CFG_WORDS-1, or CFG_WORDS with the macro.
  - After idx == LAST, go to DRAIN.
  - grid_idle is ignored once LOAD is entered.
- Write path:
  - cfg_wr_en is rd_r && (idx_r < CFG_WORDS), where rd_r and idx_r are cfg_rom_rd and idx delayed one cycle.
  - cfg_wr_addr = idx_r; cfg_wr_data = cfg_rom_data.
  - One write per word, in ascending order, no gaps.
- DRAIN: the last ROM word is returned and written. Go to DONE.
- DONE:
  - cfg_done = 1 for one cycle.
  - On a miss, set loaded_rca = target and loaded_valid = 1 on exit.
  - On a hit, registers are unchanged.
  - Go to IDLE.
- Latency, accept at cycle A:
  - Hit: cfg_done at A+1; switch_ready again at A+2.
  - Miss with grid idle: reads A+1..A+N, writes A+2..A+N+1, cfg_done at A+N+2.
  - Miss with grid busy: the schedule shifts by (WAIT_IDLE cycles).
- switch_req while busy is not accepted. The requester holds it until switch_ready.
- Back-to-back requests: the earliest next accept is the cycle after DONE.

Optional Feature:
- Macro: RCA_CFG_CHECKSUM_EN.
- Enabled:
  - LOAD also reads word CFG_WORDS, the checksum slot; it is not written to the grid.
  - An XOR accumulator is cleared on entering LOAD and XORs each written word.
  - In DRAIN, compare the accumulator to the checksum word.
  - On mismatch: set cfg_error (sticky until rst), and DONE leaves loaded_valid = 0.
  - On match: normal DONE. cfg_done pulses either way.
  - Miss latency becomes N+3.
- Disabled: no checksum read, no accumulator, cfg_error tied 0.

Test Plan:
- Reset, then request RCA 2 with grid_idle=1:
  - Reads at addrs 34..49 on A+1..A+16.
  - 16 writes, idx 0..15, data = ROM contents.
  - cfg_done at A+18; loaded_rca=2, loaded_valid=1.
- Request RCA 2 again:
  - No ROM reads or writes.
  - cfg_done at A+1; switch_ready back at A+2.
- Request RCA 1 with grid_idle=0 for 5 cycles:
  - No reads while waiting.
  - First read at addr 17, one cycle after grid_idle rises.
  - loaded_valid=0 from LOAD entry until DONE.
- Assert rst at write idx 7 during a load of RCA 3:
  - Next cycle: IDLE, switch_ready=1, loaded_valid=0, no further writes.
- switch_req held during LOAD with sel=0: not accepted until switch_ready; then loads RCA 0 (addr 0..15).
- With RCA_CFG_CHECKSUM_EN, corrupt one word of RCA 1's region:
  - cfg_done at A+19, cfg_error=1, loaded_valid=0.
  - A correct image instead gives cfg_error=0 and loaded_valid=1.
